// File: rtl/fpu_wb_ctrl_pkg.sv
// Shared FPU writeback definitions: FSM encoding, accrued-flag layout and
// the default watchdog width.
package fpu_wb_ctrl_pkg;

  localparam int TMO_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_GPR_HOLD = 2'd2
  } wb_state_e;

  // NV is bit 4 down to NX at bit 0.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/fpu_wdog.sv
// Watchdog counter for an in-flight FPU op; flags the count whose
// increment reaches the all-ones limit.
module fpu_wdog #(
  parameter int TMO_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + {{(TMO_W-1){1'b0}}, 1'b1};
  end

  assign last = (cnt == {{(TMO_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/fpu_wb_ctrl.sv
// FPU writeback controller: routes one in-flight result to the FPR file or
// the GPR handshake, accrues sticky flags and polices the protocol.
module fpu_wb_ctrl
  import fpu_wb_ctrl_pkg::*;
#(
  parameter int FPLEN = 16,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_fp_dest,
  input  logic             fpu_complete,
  input  logic             fpu_complete_rd,
  input  logic [FPLEN-1:0] fpu_result_1,
  input  logic [31:0]      fpu_result_rd,
  input  logic [4:0]       sflags,
  output logic             busy,
  output logic             fpr_we,
  output logic [4:0]       fpr_waddr,
  output logic [FPLEN-1:0] fpr_wdata,
  output logic             gpr_valid,
  input  logic             gpr_ready,
  output logic [4:0]       gpr_addr,
  output logic [31:0]      gpr_data,
  input  logic             fflags_clr,
  output logic [4:0]       fflags,
  output logic             proto_err,
  output logic             timeout
);

  wb_state_e   state, state_nxt;
  logic [4:0]  rd_q;
  logic        fp_dest_q;
  logic [31:0] gpr_data_q;
  fflags_t     fflags_q;
  logic        flag_pend;
  logic        proto_err_q, proto_err_nxt;
  logic        wd_last;
  logic        cmp_ok;

  assign cmp_ok = (state == ST_WAIT) && fpu_complete;

  fpu_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .en   (state == ST_WAIT),
    .last (wd_last)
  );

  always_comb begin
    state_nxt     = state;
    fpr_we        = 1'b0;
    timeout       = 1'b0;
    proto_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue_valid) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (fpu_complete) begin
          // completion strobe decides routing even if it disagrees with issue
          state_nxt = fpu_complete_rd ? ST_GPR_HOLD : ST_IDLE;
          fpr_we    = !fpu_complete_rd && !rst;
        end else if (wd_last) begin
          state_nxt = ST_IDLE;
          timeout   = !rst;
        end
      end
      ST_GPR_HOLD: begin
        if (gpr_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (issue_valid && state != ST_IDLE)       proto_err_nxt = 1'b1;
    if (fpu_complete && state != ST_WAIT)      proto_err_nxt = 1'b1;
    if (cmp_ok && fpu_complete_rd == fp_dest_q) proto_err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rd_q        <= '0;
      fp_dest_q   <= 1'b0;
      gpr_data_q  <= '0;
      fflags_q    <= '0;
      flag_pend   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      flag_pend   <= cmp_ok;
      proto_err_q <= proto_err_nxt;
      if (state == ST_IDLE && issue_valid) begin
        rd_q      <= issue_rd;
        fp_dest_q <= issue_fp_dest;
      end
      if (cmp_ok && fpu_complete_rd) gpr_data_q <= fpu_result_rd;
      // a pending accrual beats a same-cycle clear
      if (flag_pend)       fflags_q <= fflags_clr ? sflags : (fflags_q | sflags);
      else if (fflags_clr) fflags_q <= '0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fpr_waddr = rd_q;
  assign fpr_wdata = fpu_result_1;
  assign gpr_valid = (state == ST_GPR_HOLD);
  assign gpr_addr  = rd_q;
  assign gpr_data  = gpr_data_q;
  assign fflags    = fflags_q;
  assign proto_err = proto_err_q;

endmodule
